// File: rtl/snake_dir_ctrl.sv
// rtl/snake_dir_ctrl.sv - button conditioning and direction arbitration for the snake game core
module snake_dir_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_start,
  input  logic       step,
  input  logic       game_over,
  output logic [3:0] movement,
  output logic       start_pulse,
  output logic       dir_valid,
  output logic       dir_reject,
  output logic       run
);

  // Button index: 0 up, 1 down, 2 left, 3 right, 4 start.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  logic [4:0]       w_raw;
  logic [4:0]       r_sync1;
  logic [4:0]       r_sync2;
  logic [4:0]       r_stable;
  logic [CNT_W-1:0] r_cnt [5];
  logic [4:0]       w_rise;
  logic [3:0]       w_dir_press;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_movement, w_mov_nxt;
  logic [3:0] r_pending, w_pend_nxt;
  logic       r_pend_valid, w_pv_nxt;
  logic       r_start, w_start_nxt;
  logic       r_reject, w_reject_nxt;
  logic       r_commit, w_commit_nxt;
  logic       r_dir_valid;
  logic [3:0] w_ref;
  logic [3:0] w_opp;

  assign w_raw = {btn_start, btn_right, btn_left, btn_down, btn_up};

  // Two-flop synchroniser for every raw button.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: count consecutive cycles of disagreement, accept after the full run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stable <= '0;
      for (int i = 0; i < 5; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == LAST) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Press = the edge at which a stable level rises; direction presses are priority-filtered.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      w_rise[i] = r_sync2[i] && !r_stable[i] && (r_cnt[i] == LAST);
    end
    w_dir_press = 4'b0000;
    if (w_rise[0])      w_dir_press = 4'b0001;
    else if (w_rise[1]) w_dir_press = 4'b0010;
    else if (w_rise[2]) w_dir_press = 4'b0100;
    else if (w_rise[3]) w_dir_press = 4'b1000;
  end

  // Control state and committed direction registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_movement   <= 4'b0000;
      r_pending    <= 4'b0000;
      r_pend_valid <= 1'b0;
      r_start      <= 1'b0;
      r_reject     <= 1'b0;
      r_commit     <= 1'b0;
      r_dir_valid  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_movement   <= w_mov_nxt;
      r_pending    <= w_pend_nxt;
      r_pend_valid <= w_pv_nxt;
      r_start      <= w_start_nxt;
      r_reject     <= w_reject_nxt;
      r_commit     <= w_commit_nxt;
      r_dir_valid  <= r_commit;
    end
  end

  // Next state: step commits the old pending first, then the press is judged against it.
  always_comb begin
    w_state_nxt  = r_state;
    w_mov_nxt    = r_movement;
    w_pend_nxt   = r_pending;
    w_pv_nxt     = r_pend_valid;
    w_start_nxt  = 1'b0;
    w_reject_nxt = 1'b0;
    w_commit_nxt = 1'b0;
    w_ref        = r_pend_valid ? r_pending : r_movement;
    w_opp        = 4'b0000;
    if (game_over) begin
      w_state_nxt = S_IDLE;
      w_mov_nxt   = 4'b0000;
      w_pend_nxt  = 4'b0000;
      w_pv_nxt    = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rise[4]) begin
            w_start_nxt = 1'b1;
            w_mov_nxt   = 4'b1000;
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (step && r_pend_valid) begin
            w_mov_nxt    = r_pending;
            w_pv_nxt     = 1'b0;
            w_commit_nxt = 1'b1;
            w_ref        = r_pending;
          end
          w_opp = {w_ref[2], w_ref[3], w_ref[0], w_ref[1]};
          if (w_dir_press != 4'b0000 && w_dir_press != w_ref) begin
            if (w_dir_press == w_opp) begin
              w_reject_nxt = 1'b1;
            end else begin
              w_pend_nxt = w_dir_press;
              w_pv_nxt   = 1'b1;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign movement    = r_movement;
  assign start_pulse = r_start;
  assign dir_valid   = r_dir_valid;
  assign dir_reject  = r_reject;
  assign run         = (r_state == S_RUN);

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb/tb_snake_dir_ctrl.sv - self-checking bench for snake_dir_ctrl
module tb_snake_dir_ctrl;

  localparam int         D    = 4;
  localparam logic [7:0] MASK = 8'h0F;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] raw;
  logic       step;
  logic       game_over;
  logic [3:0] movement;
  logic       start_pulse;
  logic       dir_valid;
  logic       dir_reject;
  logic       run;

  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int n_valid = 0;
  int n_reject = 0;

  // Reference model state: directions as 0 up, 1 down, 2 left, 3 right; -1 none.
  logic [7:0] m_hist [5];
  logic [4:0] m_stable;
  logic [4:0] m_d1;
  logic [4:0] m_d2;
  bit         m_run;
  int         m_mov;
  int         m_pend;
  bit         m_pv;
  bit         m_commit_q;
  bit         m_exp_valid;
  bit         m_exp_start;
  bit         m_exp_reject;

  snake_dir_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_up     (raw[0]),
    .btn_down   (raw[1]),
    .btn_left   (raw[2]),
    .btn_right  (raw[3]),
    .btn_start  (raw[4]),
    .step       (step),
    .game_over  (game_over),
    .movement   (movement),
    .start_pulse(start_pulse),
    .dir_valid  (dir_valid),
    .dir_reject (dir_reject),
    .run        (run)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] onehot(input int d);
    return (d < 0) ? 4'b0000 : 4'(1 << d);
  endfunction

  task automatic model_edge();
    logic [4:0] rise;
    int         pdir;
    bit         commit;
    int         ref_d;
    if (!reset) begin
      for (int i = 0; i < 5; i++) m_hist[i] = 8'h00;
      m_stable = '0; m_d1 = '0; m_d2 = '0;
      m_run = 0; m_mov = -1; m_pend = -1; m_pv = 0;
      m_commit_q = 0; m_exp_valid = 0; m_exp_start = 0; m_exp_reject = 0;
      return;
    end
    rise = '0;
    for (int i = 0; i < 5; i++) begin
      m_hist[i] = {m_hist[i][6:0], m_d2[i]};
      if (!m_stable[i] && ((m_hist[i] & MASK) == MASK)) begin
        m_stable[i] = 1'b1;
        rise[i] = 1'b1;
      end else if (m_stable[i] && ((m_hist[i] & MASK) == 8'h00)) begin
        m_stable[i] = 1'b0;
      end
    end
    pdir = -1;
    for (int i = 0; i < 4; i++) if (rise[i] && pdir < 0) pdir = i;
    m_d2 = m_d1;
    m_d1 = raw;
    commit = 0;
    m_exp_start = 0;
    m_exp_reject = 0;
    m_exp_valid = m_commit_q;
    if (game_over) begin
      m_run = 0; m_mov = -1; m_pv = 0; m_pend = -1;
    end else if (!m_run) begin
      if (rise[4]) begin
        m_exp_start = 1; m_mov = 3; m_run = 1;
      end
    end else begin
      if (step && m_pv) begin
        m_mov = m_pend; m_pv = 0; commit = 1;
      end
      ref_d = m_pv ? m_pend : m_mov;
      if (pdir >= 0 && pdir != ref_d) begin
        if (pdir == (ref_d ^ 1)) m_exp_reject = 1;
        else begin
          m_pend = pdir; m_pv = 1;
        end
      end
    end
    m_commit_q = commit;
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    model_edge();
  end

  initial forever begin
    @(negedge clk);
    chk("movement", 32'(movement), 32'(onehot(m_mov)));
    chk("start_pulse", 32'(start_pulse), 32'(m_exp_start));
    chk("dir_valid", 32'(dir_valid), 32'(m_exp_valid));
    chk("dir_reject", 32'(dir_reject), 32'(m_exp_reject));
    chk("run", 32'(run), 32'(m_run));
    if (start_pulse) n_start++;
    if (dir_valid) n_valid++;
    if (dir_reject) n_reject++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int b);
    raw[b] = 1'b1;
    tick(8);
    raw[b] = 1'b0;
    tick(8);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick(1);
    step = 1'b0;
  endtask

  initial begin
    int s0, r0, v0, lat;
    raw = '0; step = 0; game_over = 0; reset = 0;
    tick(3);
    chk("reset_movement", 32'(movement), 32'h0);
    chk("reset_run", 32'(run), 32'h0);
    reset = 1;
    tick(2);

    // Short start glitch must be filtered.
    s0 = n_start;
    raw[4] = 1; tick(3); raw[4] = 0;
    tick(12);
    chk("glitch_no_start", 32'(n_start - s0), 32'd0);
    chk("glitch_run", 32'(run), 32'h0);

    // Held start: pulse 6 cycles after the rising edge.
    s0 = n_start;
    lat = 0;
    raw[4] = 1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (start_pulse && lat == 0) lat = n;
    end
    raw[4] = 0;
    tick(8);
    chk("start_latency", 32'(lat), 32'd6);
    chk("start_once", 32'(n_start - s0), 32'd1);
    chk("start_movement", 32'(movement), 32'h8);
    chk("start_run", 32'(run), 32'h1);

    // Reversal LEFT against RIGHT.
    r0 = n_reject;
    press(2);
    chk("reverse_reject", 32'(n_reject - r0), 32'd1);
    v0 = n_valid;
    pulse_step(); tick(2);
    chk("reverse_movement", 32'(movement), 32'h8);
    chk("reverse_no_valid", 32'(n_valid - v0), 32'd0);

    // Legal turn DOWN.
    r0 = n_reject;
    press(1);
    pulse_step();
    chk("turn_movement", 32'(movement), 32'h2);
    chk("turn_valid_not_yet", 32'(dir_valid), 32'h0);
    tick(1);
    chk("turn_valid", 32'(dir_valid), 32'h1);
    chk("turn_no_reject", 32'(n_reject - r0), 32'd0);

    press(3); pulse_step(); tick(2);
    chk("back_right", 32'(movement), 32'h8);

    // UP then LEFT before the step.
    r0 = n_reject;
    press(0); press(2);
    chk("race_hold", 32'(movement), 32'h8);
    pulse_step();
    chk("race_movement", 32'(movement), 32'h4);
    chk("race_no_reject", 32'(n_reject - r0), 32'd0);

    // Pending UP, DOWN press lands on the step edge.
    press(0);
    raw[1] = 1; tick(5);
    step = 1; tick(1); step = 0;
    chk("simul_movement", 32'(movement), 32'h1);
    chk("simul_reject", 32'(dir_reject), 32'h1);
    raw[1] = 0; tick(8);
    game_over = 1; step = 1; tick(1); game_over = 0; step = 0;
    chk("gameover_movement", 32'(movement), 32'h0);
    chk("gameover_run", 32'(run), 32'h0);

    // Async reset mid-cycle with pending valid.
    press(4);
    chk("restart_run", 32'(run), 32'h1);
    press(0);
    @(posedge clk); #3;
    reset = 0; #1;
    chk("async_movement", 32'(movement), 32'h0);
    chk("async_run", 32'(run), 32'h0);
    @(negedge clk);
    reset = 1;
    tick(2);
    pulse_step(); tick(2);
    chk("post_reset_movement", 32'(movement), 32'h0);
    chk("post_reset_run", 32'(run), 32'h0);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 5; b++) if ($urandom_range(11) == 0) raw[b] = ~raw[b];
      step = ($urandom_range(3) == 0);
      game_over = ($urandom_range(99) == 0);
      tick(1);
    end
    step = 0; game_over = 0; raw = '0;
    tick(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_dir_ctrl.md
Name: snake_dir_ctrl

Overview:
- Input-conditioning stage directly upstream of the snake game core.
- Synchronises and debounces the four direction buttons and the start button from the board.
- Rejects illegal reversals and emits a one-hot movement code that changes only on game step boundaries.
- Also produces a one-cycle start pulse for the game core and returns to idle on game-over.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a button level is accepted (20 ms at 50 MHz).
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low reset.
- btn_up  input  1  raw UP button, active-high, asynchronous.
- btn_down  input  1  raw DOWN button.
- btn_left  input  1  raw LEFT button.
- btn_right  input  1  raw RIGHT button.
- btn_start  input  1  raw START button.
- step  input  1  one-cycle pulse from the game core at each snake move.
- game_over  input  1  synchronous, level; forces return to IDLE.
- movement  output  4  committed direction, one-hot: UP=0001, DOWN=0010, LEFT=0100, RIGHT=1000; 0000 means no motion.
- start_pulse  output  1  one-cycle pulse on a debounced START press.
- dir_valid  output  1  one-cycle pulse in the cycle after movement changes.
- dir_reject  output  1  one-cycle pulse when a press is discarded as a reversal.
- run  output  1  high while in state RUN.

Behaviour:
- Reset (reset=0, asynchronous):
  - movement=0000; start_pulse, dir_valid, dir_reject, run=0.
  - Pending register cleared; all debounce counters and stable levels cleared.
  - Synchroniser flops cleared; state=IDLE.
- Synchronisers: two flops per button, 5 buttons.
  - Latency from raw input to synchronised level is 2 cycles.
- Debounce, per button:
  - The counter increments while the synchronised level differs from the stable level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the stable level takes the synchronised level and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the stable level.
- Press: a rising edge of a stable level gives a one-cycle internal press.
  - Releases are ignored.
  - If several direction presses occur in the same cycle, priority is UP > DOWN > LEFT > RIGHT; the others are dropped with no reject pulse.
- FSM states:
  - IDLE: direction presses are ignored and movement=0000. A start press raises start_pulse for 1 cycle, sets movement=1000 (RIGHT) and moves to RUN in the same edge.
  - RUN: run=1.
    - A direction press is evaluated against the reference direction R. R is pending if pending is valid, else movement.
    - Press equal to R: ignored.
    - Press opposite to R (UP/DOWN or LEFT/RIGHT): dir_reject=1 for 1 cycle; pending is unchanged.
    - Otherwise: the press is stored as pending (overwrites any earlier pending) and pending_valid=1.
    - On step with pending_valid=1: movement<=pending, pending_valid<=0, and dir_valid is pulsed the following cycle.
    - On step with no pending: no change.
    - A start press in RUN is ignored.
  - game_over=1 in any state: next edge gives state=IDLE, movement=0000, pending cleared, run=0. game_over overrides a simultaneous step or press.
- Simultaneous step and press in the same cycle:
  - step commits the existing pending first.
  - The press is then evaluated against that newly committed value and, if legal, becomes the new pending.
- movement changes only on step, start or game_over. It never changes mid-step, so two quick presses cannot produce a reversal within one step.
- Reset asserted mid-debounce or mid-pending: everything clears; presses are not remembered.

Test Plan:
1. Glitch filter (DEBOUNCE_CYCLES=4): reset, pulse btn_start for 3 cycles -> no start_pulse, run=0. Hold it for 8 cycles -> exactly one start_pulse, 6 cycles after the rising edge (2 synchroniser + 4 debounce); movement=1000, run=1.
2. Legal turn: in RUN with movement=1000, press DOWN, then pulse step -> movement=0010 on the step edge; dir_valid high 1 cycle later; no dir_reject.
3. Reversal: with movement=1000, press LEFT -> dir_reject 1 cycle. Then pulse step -> movement stays 1000, no dir_valid.
4. Double-press race: with movement=1000, press UP then LEFT before the next step -> LEFT is accepted against pending UP. On step, movement=0100; no reversal is ever visible on movement.
5. Simultaneous events: pending=0001 and a DOWN press in the same cycle as step -> movement=0001 and dir_reject=1. Hold game_over with step -> movement=0000, state IDLE, run=0.
6. Async reset mid-operation: drive reset=0 between clock edges while pending is valid -> all outputs 0 immediately. After release, step produces no change until START is pressed.
